// File: rtl/uart_receiver_if.sv
// Bundle of the UART receive path: serial line in, received word and status strobes out.
// master is the receiver side, slave is the line driver / downstream consumer.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] dout;
    logic                 valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        input  rx,
        output dout, valid, frame_err, parity_err, busy
    );

    modport slave (
        output rx,
        input  dout, valid, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle status strobes.
// Optional even-parity bit after the data bits when UART_RX_PARITY_EN is defined.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic            clk,
    input  logic            rst,
    uart_receiver_if.master bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY  = 3'd3,
`endif
        S_STOP    = 3'd4,
        S_RECOVER = 3'd5
    } state_e;

    state_e               state_q;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [CNT_W-1:0]     clk_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] dout_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 busy_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q;
    logic                 parity_err_q;
`endif

    // Synchronizer resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.rx};
        end
    end

    assign rx_s = sync_q[1];

    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: strobes default low each cycle, so any branch that raises one yields a single-cycle pulse.
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    busy_q    <= 1'b0;
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_q <= 1'b0;
`endif
                    if (!rx_s) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (clk_cnt_q == FULL_LAST) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= S_PARITY;
`else
                            state_q   <= S_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (clk_cnt_q == FULL_LAST) begin
                        clk_cnt_q <= '0;
                        par_bad_q <= (^shift_q) ^ rx_s;
                        state_q   <= S_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (clk_cnt_q == FULL_LAST) begin
                        clk_cnt_q <= '0;
                        if (!rx_s) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_RECOVER;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad_q) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                dout_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
`else
                            dout_q  <= shift_q;
                            valid_q <= 1'b1;
`endif
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

                // Held-low break: stay here until the line returns high.
                S_RECOVER: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout      = dout_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule
